mux4_rr_scheduler: RTL
======================

// Module: mux4_rr_scheduler
// PURPOSE
//   Round-robin scheduler that shares one 4:1 data mux between four requesting sources.
//   It arbitrates among req[3:0] and drives the mux select, with a one-hot grant alongside.
//   It forwards the selected source word to a single valid/ready output and acks each transferred word to its source.
//   A dead cycle between grants (grant=0) gives break-before-make on the select line.
// PARAMETERS
//   WIDTH       8   data width of each source word and of D_out
//   SLOT_BEATS  4   max transfers per grant before forced release (legal range 1..255)
// PORTS
//   clk        in   1      rising-edge clock, only clock
//   rst        in   1      synchronous reset, active-high
//   req        in   4      req[i]=1: source i has a word on D_i
//   D_0..D_3   in   WIDTH  source data words
//   out_ready  in   1      downstream can accept D_out this cycle
//   D_out      out  WIDTH  D_<select>, combinational from the registered select
//   out_valid  out  1      D_out holds a valid word
//   select     out  2      registered mux select, index of current or last grant
//   grant      out  4      registered one-hot grant, 0 when no grant is active
//   ack        out  4      ack[i]=1: word from source i is transferred this cycle
//   busy       out  1      1 in GRANT or GAP state
// BEHAVIOUR
//   Reset (rst=1 at posedge): state=IDLE, select=0, grant=0, beat_cnt=0, last=3.
//     Outputs during and after reset: out_valid=0, ack=0, busy=0.
//     Reset overrides everything, including mid-grant; any in-flight handshake that cycle is discarded.
//   FSM states are IDLE, GRANT and GAP.
//   IDLE:
//     grant=0, out_valid=0.
//     If req!=0, the winner is the first i with req[i]=1, scanning last+1, last+2, ... (mod 4).
//     On the next edge: state=GRANT, select=winner, grant=1<<winner, last=winner, beat_cnt=0.
//     Latency from req rising to grant is 1 cycle.
//   GRANT (let s = select):
//     out_valid = req[s].
//     A handshake is xfer = out_valid & out_ready; then ack[s]=1, and all other ack bits are always 0.
//     On xfer, beat_cnt increments.
//     If xfer and beat_cnt==SLOT_BEATS-1, the next state is GAP (slot exhausted).
//     If req[s]=0, the next state is GAP at once (source withdrew); no ack that cycle.
//     Otherwise the state stays GRANT; out_ready=0 stalls indefinitely with no timeout.
//   GAP:
//     Always exactly 1 cycle; grant=0, out_valid=0, select holds.
//     Arbitration is identical to IDLE.
//     Next state is GRANT with the new winner if req!=0, else IDLE.
//     The previous owner is lowest priority, because last was updated on grant.
//   select changes only on entry to GRANT; it holds in IDLE and GAP.
//   D_out = D_<select> at all times; it is don't-care when out_valid=0.
//   Fairness: with all four requesting continuously, order is 0,1,2,3,0,...
//     Each grant moves SLOT_BEATS words when out_ready=1.
//   Changes to req bits other than req[s] during GRANT have no effect until the next arbitration.
//   beat_cnt is $clog2(SLOT_BEATS+1) bits wide and never wraps, because of the SLOT_BEATS-1 check.
// TESTING
//   1. Reset then idle:
//      rst=1 for 2 cycles, req=0 -> grant=0, select=0, out_valid=0, busy=0, ack=0 throughout.
//   2. Single source:
//      req=4'b0100, D_2=8'hA5, out_ready=1 -> 1 cycle later select=2, grant=4'b0100.
//      Then 4 cycles of out_valid=1, D_out=A5, ack=4'b0100.
//      Then 1 GAP cycle, then re-grant of 2.
//   3. Round-robin:
//      req=4'b1111, out_ready=1 -> grant sequence 0,1,2,3,0.
//      Each grant gives 4 acks followed by 1 dead cycle, i.e. 5-cycle period per source.
//   4. Backpressure:
//      Grant to 1, out_ready=0 for 10 cycles -> out_valid=1, ack=0, and beat_cnt holds.
//      Then out_ready=1 -> 4 acks, then GAP.
//   5. Withdrawal:
//      Grant to 3, req[3] drops after 2 acks -> next cycle GAP, out_valid=0.
//      Then grant goes to 0 if req[0]=1.
//   6. Reset mid-grant:
//      rst=1 during GRANT of source 2 -> next cycle grant=0, select=0, out_valid=0.
//      After release, with req=4'b1111, the first grant is to 0.

Source files
------------

// File: rtl/mux4_rr_scheduler_if.sv
// Bus bundle between four sources, the round-robin scheduler and one downstream sink.
// The scheduler uses the slave modport. The environment that drives the sources and the sink uses the master modport.
interface mux4_rr_scheduler_if #(
    parameter int unsigned WIDTH = 8
);
    logic [3:0]       req;
    logic [WIDTH-1:0] D_0;
    logic [WIDTH-1:0] D_1;
    logic [WIDTH-1:0] D_2;
    logic [WIDTH-1:0] D_3;
    logic             out_ready;
    logic [WIDTH-1:0] D_out;
    logic             out_valid;
    logic [1:0]       select;
    logic [3:0]       grant;
    logic [3:0]       ack;
    logic             busy;

    modport slave (
        input  req, D_0, D_1, D_2, D_3, out_ready,
        output D_out, out_valid, select, grant, ack, busy
    );

    modport master (
        output req, D_0, D_1, D_2, D_3, out_ready,
        input  D_out, out_valid, select, grant, ack, busy
    );
endinterface

// File: rtl/mux4_rr_scheduler.sv
// Round-robin scheduler that shares a 4:1 data mux between four sources.
// Each grant is followed by a one-cycle dead gap, so the select line breaks before it makes.
module mux4_rr_scheduler #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned SLOT_BEATS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    mux4_rr_scheduler_if.slave   bus
);
    localparam int unsigned CW = $clog2(SLOT_BEATS + 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(SLOT_BEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_GAP
    } state_t;

    state_t        state_q,    state_d;
    logic [1:0]    select_q,   select_d;
    logic [3:0]    grant_q,    grant_d;
    logic [CW-1:0] beat_cnt_q, beat_cnt_d;
    logic [1:0]    last_q,     last_d;

    logic [1:0] winner;
    logic       found;
    logic       out_valid_c;
    logic       xfer;

    // The scan starts just after the previous owner, which makes that owner the lowest priority.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int unsigned k = 1; k <= 4; k++) begin
            logic [1:0] idx;
            idx = last_q + 2'(k);
            if (!found && bus.req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    // Reset suppresses the handshake in the same cycle, so an in-flight word is neither acked nor counted.
    always_comb begin
        out_valid_c = (state_q == S_GRANT) && bus.req[select_q] && !rst;
        xfer        = out_valid_c && bus.out_ready;
    end

    always_comb begin
        state_d    = state_q;
        select_d   = select_q;
        grant_d    = grant_q;
        beat_cnt_d = beat_cnt_q;
        last_d     = last_q;
        unique case (state_q)
            S_GRANT: begin
                if (!bus.req[select_q]) begin
                    state_d = S_GAP;
                    grant_d = '0;
                end else if (xfer) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d = S_GAP;
                        grant_d = '0;
                    end
                end
            end
            default: begin
                if (found) begin
                    state_d    = S_GRANT;
                    select_d   = winner;
                    grant_d    = 4'b0001 << winner;
                    last_d     = winner;
                    beat_cnt_d = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            select_q   <= '0;
            grant_q    <= '0;
            beat_cnt_q <= '0;
            last_q     <= 2'd3;
        end else begin
            state_q    <= state_d;
            select_q   <= select_d;
            grant_q    <= grant_d;
            beat_cnt_q <= beat_cnt_d;
            last_q     <= last_d;
        end
    end

    always_comb begin
        unique case (select_q)
            2'd0:    bus.D_out = bus.D_0;
            2'd1:    bus.D_out = bus.D_1;
            2'd2:    bus.D_out = bus.D_2;
            default: bus.D_out = bus.D_3;
        endcase
        bus.out_valid = out_valid_c;
        bus.select    = select_q;
        bus.grant     = grant_q;
        bus.ack       = xfer ? (4'b0001 << select_q) : '0;
        bus.busy      = (state_q != S_IDLE) && !rst;
    end
endmodule
